// File: rtl/pio_edge_irq_deb.sv
// ---------------------------------------------------------------------------
// pio_edge_irq_deb
//
// Avalon-MM PIO slave for board buttons/switches. Each of the WIDTH inputs is
// brought into the clk domain by a 2-flop synchroniser. A per-channel debounce
// filter then accepts a new level only after DEBOUNCE_CYCLES consecutive
// differing samples. Rising and/or falling edges of the debounced level are
// latched in a write-1-to-clear capture register. A maskable level interrupt
// is raised from the captured bits.
//
// Register map (32-bit words, reads zero-extended, one-cycle read latency):
//   0 RO  stable        debounced input levels
//   1 RO  s2            raw synchronised input levels
//   2 RW  irq_mask      interrupt enable per channel
//   3 W1C edge_capture  latched edges; an edge in the same cycle wins
//   4 RW  rise_en       capture rising edges
//   5 RW  fall_en       capture falling edges
//   6,7   read 0, writes ignored
//
// Ports:
//   clk         system clock
//   reset_n     asynchronous active-low reset
//   address     Avalon word address
//   chipselect  slave select
//   write_n     active-low write strobe
//   writedata   write data, bits above WIDTH ignored
//   in_port     asynchronous external inputs
//   readdata    registered read data
//   irq         level interrupt, active high
// ---------------------------------------------------------------------------
module pio_edge_irq_deb #(
  parameter int unsigned       WIDTH           = 2,
  parameter int unsigned       DEBOUNCE_CYCLES = 16,
  parameter logic [WIDTH-1:0]  FALL_EN_RESET   = '1,
  parameter logic [WIDTH-1:0]  RISE_EN_RESET   = '0
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [2:0]        address,
  input  logic              chipselect,
  input  logic              write_n,
  input  logic [31:0]       writedata,
  input  logic [WIDTH-1:0]  in_port,
  output logic [31:0]       readdata,
  output logic              irq
);

  localparam int unsigned CNT_W =
    (DEBOUNCE_CYCLES == 0) ? 1 : $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST =
    CNT_W'((DEBOUNCE_CYCLES == 0) ? 0 : DEBOUNCE_CYCLES - 1);

  localparam logic [2:0] ADDR_DATA  = 3'd0;
  localparam logic [2:0] ADDR_RAW   = 3'd1;
  localparam logic [2:0] ADDR_MASK  = 3'd2;
  localparam logic [2:0] ADDR_EDGE  = 3'd3;
  localparam logic [2:0] ADDR_RISE  = 3'd4;
  localparam logic [2:0] ADDR_FALL  = 3'd5;

  logic [WIDTH-1:0] s1;
  logic [WIDTH-1:0] s2;
  wire  [WIDTH-1:0] stable;
  logic [WIDTH-1:0] prev_stable;
  logic [WIDTH-1:0] irq_mask;
  logic [WIDTH-1:0] edge_capture;
  logic [WIDTH-1:0] rise_en;
  logic [WIDTH-1:0] fall_en;

  logic [WIDTH-1:0] edge_det;
  logic [WIDTH-1:0] cap_clr;
  logic [WIDTH-1:0] rd_mux;
  logic             wr_en;

  // Upper writedata bits are intentionally ignored for narrow builds.
  logic unused_wdata;
  assign unused_wdata = ^writedata;

  // -------------------------------------------------------------------------
  // Synchroniser
  // -------------------------------------------------------------------------
  // NOTE: every clocked register uses <= so all flops sample pre-edge values;
  // blocking assignments here would collapse s1/s2 into a single stage.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      s1 <= '0;
      s2 <= '0;
    end else begin
      s1 <= in_port;
      s2 <= s1;
    end
  end

  // -------------------------------------------------------------------------
  // Per-channel debounce filter
  // -------------------------------------------------------------------------
  for (genvar g = 0; g < WIDTH; g++) begin : g_deb
    logic stable_q;
    assign stable[g] = stable_q;

    if (DEBOUNCE_CYCLES == 0) begin : g_bypass
      always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) stable_q <= 1'b0;
        else          stable_q <= s2[g];
      end
    end else begin : g_filter
      logic [CNT_W-1:0] cnt;

      // NOTE: the run counters are reset along with the data path so a reset
      // in the middle of a debounce window never leaves a partial count.
      always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
          stable_q <= 1'b0;
          cnt      <= '0;
        end else if (s2[g] == stable_q) begin
          // Glitch back to the accepted level restarts the window.
          cnt      <= '0;
        end else if (cnt == CNT_LAST) begin
          stable_q <= s2[g];
          cnt      <= '0;
        end else begin
          cnt      <= cnt + 1'b1;
        end
      end
    end
  end

  // -------------------------------------------------------------------------
  // Edge detect and bus decode
  // -------------------------------------------------------------------------
  assign edge_det = (stable & ~prev_stable & rise_en) |
                    (~stable & prev_stable & fall_en);

  assign wr_en   = chipselect & ~write_n;
  assign cap_clr = (wr_en && address == ADDR_EDGE) ? writedata[WIDTH-1:0] : '0;

  // NOTE: rd_mux gets a default before the case so no address leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    rd_mux = '0;
    case (address)
      ADDR_DATA: rd_mux = stable;
      ADDR_RAW:  rd_mux = s2;
      ADDR_MASK: rd_mux = irq_mask;
      ADDR_EDGE: rd_mux = edge_capture;
      ADDR_RISE: rd_mux = rise_en;
      ADDR_FALL: rd_mux = fall_en;
      default:   rd_mux = '0;
    endcase
  end

  // -------------------------------------------------------------------------
  // Control/status registers and registered read port
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      prev_stable  <= '0;
      irq_mask     <= '0;
      edge_capture <= '0;
      rise_en      <= RISE_EN_RESET;
      fall_en      <= FALL_EN_RESET;
      readdata     <= '0;
    end else begin
      prev_stable  <= stable;
      // Set has priority over clear so an edge arriving with the W1C write
      // is never lost.
      edge_capture <= (edge_capture & ~cap_clr) | edge_det;
      if (wr_en) begin
        case (address)
          ADDR_MASK: irq_mask <= writedata[WIDTH-1:0];
          ADDR_RISE: rise_en  <= writedata[WIDTH-1:0];
          ADDR_FALL: fall_en  <= writedata[WIDTH-1:0];
          default:   ;
        endcase
      end
      // Read mux samples pre-write register values, independent of chipselect.
      readdata     <= 32'(rd_mux);
    end
  end

  // Decoded from registers only: no combinational path from in_port.
  assign irq = |(edge_capture & irq_mask);

endmodule

// File: tb/tb_pio_edge_irq_deb.sv
// ---------------------------------------------------------------------------
// tb_pio_edge_irq_deb
//
// Self-checking bench for pio_edge_irq_deb. A WIDTH=4, N=8 instance is
// compared against a reference model that keeps the raw input sample history
// and accepts a level once the last N synchronised samples all disagree with
// the current debounced level. A second WIDTH=4, N=0 instance shares the bus
// and inputs and is checked with directed expectations.
// ---------------------------------------------------------------------------
module tb_pio_edge_irq_deb;

  localparam int W = 4;
  localparam int N = 8;

  logic          clk = 1'b0;
  logic          reset_n;
  logic [2:0]    address;
  logic          chipselect;
  logic          write_n;
  logic [31:0]   writedata;
  logic [W-1:0]  in_port;
  logic [31:0]   readdata;
  logic          irq;
  logic [31:0]   readdata0;
  logic          irq0;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  pio_edge_irq_deb #(.WIDTH(W), .DEBOUNCE_CYCLES(N)) dut (
    .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
    .write_n(write_n), .writedata(writedata), .in_port(in_port),
    .readdata(readdata), .irq(irq)
  );

  pio_edge_irq_deb #(.WIDTH(W), .DEBOUNCE_CYCLES(0)) dut0 (
    .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
    .write_n(write_n), .writedata(writedata), .in_port(in_port),
    .readdata(readdata0), .irq(irq0)
  );

  // -------------------------------------------------------------------------
  // Reference model for the N=8 instance
  // -------------------------------------------------------------------------
  // hist[0] is the most recent in_port sample; hist[1] is what the second
  // synchroniser stage currently holds, hist[N] the oldest sample of interest.
  logic [W-1:0] hist [0:N];
  logic [W-1:0] m_stable, m_prev, m_cap, m_mask, m_rise, m_fall;
  logic [31:0]  m_rd;
  wire  [W-1:0] m_edge = (m_stable & ~m_prev & m_rise) | (~m_stable & m_prev & m_fall);
  wire          m_irq  = |(m_cap & m_mask);
  wire          m_wr   = chipselect && !write_n;

  // Bits whose last N synchronised samples all disagree with the accepted level.
  function automatic logic [W-1:0] accept_flips();
    logic [W-1:0] f = '1;
    for (int j = 1; j <= N; j++) f &= hist[j] ^ m_stable;
    return f;
  endfunction

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int j = 0; j <= N; j++) hist[j] <= '0;
      m_stable <= '0;
      m_prev   <= '0;
      m_cap    <= '0;
      m_mask   <= '0;
      m_rise   <= '0;
      m_fall   <= '1;
      m_rd     <= '0;
    end else begin
      hist[0] <= in_port;
      for (int j = 1; j <= N; j++) hist[j] <= hist[j-1];
      m_stable <= m_stable ^ accept_flips();
      m_prev   <= m_stable;
      m_cap    <= (m_cap & ~((m_wr && address == 3'd3) ? writedata[W-1:0] : '0)) | m_edge;
      if (m_wr) begin
        if (address == 3'd2) m_mask <= writedata[W-1:0];
        if (address == 3'd4) m_rise <= writedata[W-1:0];
        if (address == 3'd5) m_fall <= writedata[W-1:0];
      end
      case (address)
        3'd0:    m_rd <= 32'(m_stable);
        3'd1:    m_rd <= 32'(hist[1]);
        3'd2:    m_rd <= 32'(m_mask);
        3'd3:    m_rd <= 32'(m_cap);
        3'd4:    m_rd <= 32'(m_rise);
        3'd5:    m_rd <= 32'(m_fall);
        default: m_rd <= '0;
      endcase
    end
  end

  // -------------------------------------------------------------------------
  // Bus helpers (stimulus only; inputs change on the falling edge)
  // -------------------------------------------------------------------------
  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic bus_write(input logic [2:0] a, input logic [31:0] d);
    address    = a;
    writedata  = d;
    chipselect = 1'b1;
    write_n    = 1'b0;
    @(negedge clk);
    chipselect = 1'b0;
    write_n    = 1'b1;
  endtask

  task automatic read_reg(input logic [2:0] a, output logic [31:0] d);
    address = a;
    @(negedge clk);
    d = readdata;
  endtask

  // -------------------------------------------------------------------------
  // Scenarios
  // -------------------------------------------------------------------------
  task automatic test_reset();
    logic [31:0] d;
    reset_n    = 1'b0;
    address    = 3'd0;
    chipselect = 1'b0;
    write_n    = 1'b1;
    writedata  = '0;
    in_port    = 4'hF;
    tick(3);
    checks++;
    if (readdata !== 32'd0 || irq !== 1'b0) begin
      failures++;
      $display("FAIL reset_outputs: readdata=%h irq=%b, required 0/0", readdata, irq);
    end
    reset_n = 1'b1;
    tick(10);
    checks++;
    if (readdata !== 32'd0) begin
      failures++;
      $display("FAIL reset_latency_early: readdata=%h, required 0", readdata);
    end
    tick(1);
    checks++;
    if (readdata !== 32'hF || readdata !== m_rd) begin
      failures++;
      $display("FAIL reset_stable: readdata=%h, required %h (model %h)", readdata, 32'hF, m_rd);
    end
    read_reg(3'd3, d);
    checks++;
    if (d !== 32'd0 || irq !== 1'b0) begin
      failures++;
      $display("FAIL reset_no_rise_capture: edge_capture=%h irq=%b, required 0/0", d, irq);
    end
  endtask

  task automatic test_fall_irq();
    logic [31:0] d;
    bus_write(3'd2, 32'h1);
    in_port = 4'hE;
    tick(10);
    checks++;
    if (irq !== 1'b0 || irq !== m_irq) begin
      failures++;
      $display("FAIL fall_irq_early: irq=%b, required 0", irq);
    end
    tick(1);
    checks++;
    if (irq !== 1'b1 || irq !== m_irq) begin
      failures++;
      $display("FAIL fall_irq_assert: irq=%b, required 1", irq);
    end
    read_reg(3'd3, d);
    checks++;
    if (d !== 32'h1 || d !== m_rd) begin
      failures++;
      $display("FAIL fall_capture: edge_capture=%h, required 1", d);
    end
    bus_write(3'd3, 32'h1);
    checks++;
    if (irq !== 1'b0 || irq !== m_irq) begin
      failures++;
      $display("FAIL fall_w1c_irq: irq=%b, required 0", irq);
    end
    read_reg(3'd3, d);
    checks++;
    if (d !== 32'h0) begin
      failures++;
      $display("FAIL fall_w1c_clear: edge_capture=%h, required 0", d);
    end
  endtask

  task automatic test_glitch();
    logic [31:0] d;
    in_port = 4'hC;
    tick(5);
    in_port = 4'hE;
    tick(20);
    read_reg(3'd3, d);
    checks++;
    if (d !== 32'h0 || d !== m_rd) begin
      failures++;
      $display("FAIL glitch_rejected: edge_capture=%h, required 0", d);
    end
    read_reg(3'd0, d);
    checks++;
    if (d !== 32'hE || d !== m_rd) begin
      failures++;
      $display("FAIL glitch_stable: stable=%h, required e", d);
    end
    in_port = 4'hC;
    tick(12);
    read_reg(3'd3, d);
    checks++;
    if (d !== 32'h2 || d !== m_rd) begin
      failures++;
      $display("FAIL glitch_long_low: edge_capture=%h, required 2", d);
    end
    bus_write(3'd3, 32'hF);
  endtask

  task automatic test_rise_mode();
    logic [31:0] d;
    bus_write(3'd4, 32'h4);
    bus_write(3'd5, 32'h0);
    in_port = 4'h8;
    tick(20);
    read_reg(3'd3, d);
    checks++;
    if (d !== 32'h0 || d !== m_rd) begin
      failures++;
      $display("FAIL rise_ignores_fall: edge_capture=%h, required 0", d);
    end
    in_port = 4'hC;
    tick(20);
    read_reg(3'd3, d);
    checks++;
    if (d !== 32'h4 || d !== m_rd) begin
      failures++;
      $display("FAIL rise_capture: edge_capture=%h, required 4", d);
    end
    read_reg(3'd4, d);
    checks++;
    if (d !== 32'h4) begin
      failures++;
      $display("FAIL rise_en_readback: rise_en=%h, required 4", d);
    end
    bus_write(3'd3, 32'hF);
  endtask

  task automatic test_back_to_back();
    logic [31:0] d;
    bus_write(3'd5, 32'h8);
    in_port = 4'h4;
    // stable[3] falls on edge 10, so the W1C write lands with edge[3] set.
    tick(10);
    bus_write(3'd3, 32'h8);
    read_reg(3'd3, d);
    checks++;
    if (d !== 32'h8 || d !== m_rd) begin
      failures++;
      $display("FAIL set_wins_clear: edge_capture=%h, required 8", d);
    end
    bus_write(3'd3, 32'hF);
    read_reg(3'd3, d);
    checks++;
    if (d !== 32'h0) begin
      failures++;
      $display("FAIL set_then_clear: edge_capture=%h, required 0", d);
    end
  endtask

  task automatic test_random();
    int hold = 0;
    for (int c = 0; c < 600; c++) begin
      if (hold == 0) begin
        in_port = in_port ^ W'($urandom_range(1, 15));
        hold    = $urandom_range(1, 14);
      end else begin
        hold--;
      end
      address = 3'($urandom_range(0, 7));
      if ($urandom_range(0, 5) == 0) begin
        writedata  = $urandom;
        chipselect = 1'b1;
        write_n    = 1'b0;
      end else begin
        chipselect = $urandom_range(0, 1) == 1;
        write_n    = 1'b1;
      end
      @(negedge clk);
      checks++;
      if (readdata !== m_rd || irq !== m_irq) begin
        failures++;
        $display("FAIL random_cycle_%0d: readdata=%h irq=%b, required %h/%b",
                 c, readdata, irq, m_rd, m_irq);
      end
    end
    chipselect = 1'b0;
    write_n    = 1'b1;
  endtask

  task automatic test_nzero_and_async_reset();
    in_port = 4'h5;
    tick(12);
    bus_write(3'd4, 32'hF);
    bus_write(3'd5, 32'hF);
    bus_write(3'd2, 32'hF);
    bus_write(3'd3, 32'hF);
    address = 3'd0;
    tick(2);
    checks++;
    if (readdata0 !== 32'h5 || irq0 !== 1'b0) begin
      failures++;
      $display("FAIL nzero_settled: readdata=%h irq=%b, required 5/0", readdata0, irq0);
    end
    in_port = 4'hA;
    tick(3);
    checks++;
    if (readdata0 !== 32'h5) begin
      failures++;
      $display("FAIL nzero_latency_early: readdata=%h, required 5", readdata0);
    end
    tick(1);
    checks++;
    if (readdata0 !== 32'hA || irq0 !== 1'b1) begin
      failures++;
      $display("FAIL nzero_change: readdata=%h irq=%b, required a/1", readdata0, irq0);
    end
    // Assert reset between clock edges and look before the next rising edge.
    #2 reset_n = 1'b0;
    #1;
    checks++;
    if (readdata0 !== 32'd0 || irq0 !== 1'b0 || readdata !== 32'd0 || irq !== 1'b0) begin
      failures++;
      $display("FAIL async_reset: n0 readdata=%h irq=%b n8 readdata=%h irq=%b, required all 0",
               readdata0, irq0, readdata, irq);
    end
    @(negedge clk);
    reset_n = 1'b1;
    address = 3'd3;
    @(negedge clk);
    checks++;
    if (readdata0 !== 32'd0 || readdata !== m_rd) begin
      failures++;
      $display("FAIL async_reset_capture: n0 edge_capture=%h n8 readdata=%h, required 0/%h",
               readdata0, readdata, m_rd);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_fall_irq();
    test_glitch();
    test_rise_mode();
    test_back_to_back();
    test_random();
    test_nzero_and_async_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
